// File: rtl/coin_pkg.sv
// Shared coin definitions for the payout (dispenser) and acceptor-side logic:
// FSM state encoding, coin denominations and the default change limit.
package coin_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  typedef enum logic {
    COIN_100 = 1'b0,
    COIN_500 = 1'b1
  } coin_t;

  localparam int COIN500_UNITS      = 5;
  localparam int COIN100_UNITS      = 1;
  localparam int MAX_AMOUNT_DEFAULT = 11;

  // Value of a coin in 100-colon units, sized to the 8-bit amount datapath.
  function automatic logic [7:0] coin_units(input coin_t c);
    return (c == COIN_500) ? 8'(COIN500_UNITS) : 8'(COIN100_UNITS);
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy coin chooser: a 500 coin whenever at least five units
// are owed and one is in stock, otherwise a 100 coin.
module coin_select
  import coin_pkg::*;
(
  input  logic [7:0] remaining,
  input  logic       stock_ok,
  output coin_t      coin_sel,
  output logic [7:0] dec
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned, which would infer a latch.
    coin_sel = COIN_100;
    if (stock_ok && (remaining >= 8'(COIN500_UNITS))) begin
      coin_sel = COIN_500;
    end
    dec = coin_units(coin_sel);
  end

endmodule

// File: rtl/coin_dispenser.sv
// Change-payout FSM driving the 500/100 coin-eject solenoids, paced by tick.
// Define COIN_STOCK_EN to track a finite 500-colon hopper (STOCK_500 coins).
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int MAX_AMOUNT = MAX_AMOUNT_DEFAULT,
  parameter int STOCK_500  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [7:0] amount,
  output logic       eject500,
  output logic       eject100,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] remaining
);

  state_t     state;
  coin_t      sel_c;
  logic [7:0] dec_c;
  logic [7:0] dec_q;
  logic       stock_ok;

  coin_select u_select (
    .remaining (remaining),
    .stock_ok  (stock_ok),
    .coin_sel  (sel_c),
    .dec       (dec_c)
  );

`ifdef COIN_STOCK_EN
  logic [7:0] stock_q;

  // Counts down once per 500 coin, at the SELECT cycle that commits to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stock_q <= 8'(STOCK_500);
    end else if ((state == S_SELECT) && (remaining != '0) && (sel_c == COIN_500)) begin
      stock_q <= stock_q - 8'd1;
    end
  end

  assign stock_ok = (stock_q != '0);
`else
  // Bottomless 500 hopper; STOCK_500 has no effect in this build.
  assign stock_ok = 1'b1 | (STOCK_500 != 0);
`endif

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // wins over every other input on the edge where it is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      eject500  <= 1'b0;
      eject100  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
      dec_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments for all registered state, so every
      // right-hand side sees the values from before this edge.
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (amount > 8'(MAX_AMOUNT)) begin
              err <= 1'b1;
            end else begin
              remaining <= amount;
              busy      <= 1'b1;
              state     <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            dec_q    <= dec_c;
            eject500 <= (sel_c == COIN_500);
            eject100 <= (sel_c == COIN_100);
            state    <= S_PULSE;
          end
        end
        S_PULSE: begin
          // Chooser guaranteed remaining >= coin value, so no underflow here.
          if (tick) begin
            remaining <= remaining - dec_q;
            eject500  <= 1'b0;
            eject100  <= 1'b0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (tick) begin
            state <= S_SELECT;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_dispenser.sv
// Self-checking bench for coin_dispenser: vector table, hand-written reset
// and stock sequences, and randomized payouts against a greedy change model.
module tb_coin_dispenser;

  localparam int MAXA = 11;
`ifdef COIN_STOCK_EN
  localparam int STOCK = 1;
`else
  localparam int STOCK = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic [7:0] amount;
  logic       eject500;
  logic       eject100;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] remaining;

  always #5 clk = ~clk;

  coin_dispenser #(
    .MAX_AMOUNT (MAXA),
    .STOCK_500  (STOCK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .amount    (amount),
    .eject500  (eject500),
    .eject100  (eject100),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining)
  );

  typedef struct {
    int amt;
    int div;
    int mid_k;
    int exp_err;
    int exp_n500;
    int exp_n100;
    int exp_lat;
    int exp_busy;
    int exp_hi500;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_stock;
  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_model();
`ifdef COIN_STOCK_EN
    model_stock = STOCK;
`else
    model_stock = 1 << 30;
`endif
  endtask

  // Greedy change split with a finite 500 hopper; 100 hopper is unlimited.
  task automatic ref_payout(input int amt, output int e, output int n5, output int n1);
    if (amt > MAXA) begin
      e = 1; n5 = 0; n1 = 0;
    end else begin
      e  = 0;
      n5 = amt / 5;
      if (n5 > model_stock) n5 = model_stock;
      model_stock -= n5;
      n1 = amt - 5 * n5;
    end
  endtask

  task automatic run_txn(input int amt, input int div, input int mid_k,
                         output int r_err, output int r_n500, output int r_n100,
                         output int r_lat, output int r_busy, output int r_hi500,
                         output int r_both, output int r_done, output int r_rem0,
                         output int r_remend, output int r_to);
    logic p500, p100;
    int   k;
    r_err = 0; r_n500 = 0; r_n100 = 0; r_lat = -1; r_busy = 0; r_hi500 = 0;
    r_both = 0; r_done = 0; r_rem0 = 0; r_remend = 0; r_to = 0;
    @(negedge clk);
    start  = 1'b1;
    amount = 8'(amt);
    tick   = (div == 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    p500  = 1'b0;
    p100  = 1'b0;
    k     = 0;
    forever begin
      if (k == 0) r_rem0 = int'(remaining);
      if (err) r_err++;
      if (done) begin
        r_done++;
        if (r_lat < 0) r_lat = k;
      end
      if (busy) r_busy++;
      if (eject500) r_hi500++;
      if (eject500 && !p500) r_n500++;
      if (eject100 && !p100) r_n100++;
      if (eject500 && eject100) r_both++;
      p500 = eject500;
      p100 = eject100;
      if (k >= 1 && !busy) break;
      if (k >= 400) begin
        r_to = 1;
        break;
      end
      start  = (k == mid_k);
      amount = 8'd3;
      tick   = (div == 1) || (((k + 1) % div) == 0);
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    start    = 1'b0;
    r_remend = int'(remaining);
  endtask

  task automatic do_vec(input string tag, input vec_t v);
    int r_err, r_n500, r_n100, r_lat, r_busy, r_hi500, r_both, r_done, r_rem0, r_remend, r_to;
    run_txn(v.amt, v.div, v.mid_k, r_err, r_n500, r_n100, r_lat, r_busy, r_hi500,
            r_both, r_done, r_rem0, r_remend, r_to);
    check({tag, " timeout"}, r_to, 0);
    check({tag, " err"}, r_err, v.exp_err);
    check({tag, " n500"}, r_n500, v.exp_n500);
    check({tag, " n100"}, r_n100, v.exp_n100);
    check({tag, " done_count"}, r_done, (v.exp_err != 0) ? 0 : 1);
    check({tag, " both_ejects"}, r_both, 0);
    check({tag, " remaining_loaded"}, r_rem0, (v.exp_err != 0) ? 0 : v.amt);
    check({tag, " remaining_end"}, r_remend, 0);
    if (v.exp_lat >= 0) check({tag, " done_latency"}, r_lat, v.exp_lat);
    if (v.exp_busy >= 0) check({tag, " busy_cycles"}, r_busy, v.exp_busy);
    if (v.exp_hi500 >= 0) check({tag, " eject500_cycles"}, r_hi500, v.exp_hi500);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   e, n5, n1;
    vec_t v;

    //            amt div mid err n5 n1 lat busy hi500
    vecs[0] = '{  8,  1, -1,  0, 1, 3, 13, 14, 1};
    vecs[1] = '{  0,  1, -1,  0, 0, 0,  1,  2, 0};
    vecs[2] = '{ 12,  1, -1,  1, 0, 0, -1,  0, 0};
    vecs[3] = '{ 11,  1, -1,  0, 2, 1, 10, 11, 2};
    vecs[4] = '{  5,  4,  5,  0, 1, 0,  9, 10, 3};
    vecs[5] = '{  4,  1, -1,  0, 0, 4, 13, 14, 0};
    vecs[6] = '{255,  1, -1,  1, 0, 0, -1,  0, 0};
    vecs[7] = '{ 10,  2,  3,  0, 2, 0,  9, 10, 2};
    vecs[8] = '{  1,  3, -1,  0, 0, 1,  7,  8, 0};
    vecs[9] = '{  6,  1,  2,  0, 1, 1,  7,  8, 1};

    // Reset with start asserted: reset must win and leave everything idle.
    rst    = 1'b1;
    tick   = 1'b1;
    start  = 1'b1;
    amount = 8'd5;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset eject500", int'(eject500), 0);
    check("reset eject100", int'(eject100), 0);
    check("reset done", int'(done), 0);
    check("reset err", int'(err), 0);
    check("reset remaining", int'(remaining), 0);
    start = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
`ifdef COIN_STOCK_EN
      ref_payout(v.amt, e, n5, n1);
      if (n5 != v.exp_n500) begin
        v.exp_n500  = n5;
        v.exp_n100  = n1;
        v.exp_lat   = (v.div == 1) ? 3 * (n5 + n1) + 1 : -1;
        v.exp_busy  = (v.exp_lat >= 0) ? v.exp_lat + 1 : -1;
        v.exp_hi500 = (v.div == 1) ? n5 : -1;
      end
`endif
      do_vec($sformatf("vec%0d", i), v);
    end

    // Reset in the middle of a payout of 11 units.
    @(negedge clk);
    start  = 1'b1;
    amount = 8'd11;
    tick   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !(eject500 || eject100); i++) @(negedge clk);
    check("midrst eject_seen", int'(eject500 | eject100), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy", int'(busy), 0);
    check("midrst eject500", int'(eject500), 0);
    check("midrst eject100", int'(eject100), 0);
    check("midrst done", int'(done), 0);
    check("midrst remaining", int'(remaining), 0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    ref_payout(3, e, n5, n1);
    do_vec("after_rst", '{3, 1, -1, 0, 0, 3, 10, 11, 0});

`ifdef COIN_STOCK_EN
    // One 500 coin left in stock: the rest of 11 is paid in 100 coins.
    ref_payout(11, e, n5, n1);
    do_vec("stock_11", '{11, 1, -1, 0, 1, 6, 22, 23, 1});
`endif

    // Randomized payouts against the greedy model.
    for (int i = 0; i < 40; i++) begin
      v.amt = int'($urandom_range(0, 14));
      v.div = int'($urandom_range(1, 4));
      ref_payout(v.amt, e, n5, n1);
      v.exp_err   = e;
      v.exp_n500  = n5;
      v.exp_n100  = n1;
      v.mid_k     = (e != 0) ? -1 : int'($urandom_range(0, 6));
      v.exp_lat   = (e == 0 && v.div == 1) ? 3 * (n5 + n1) + 1 : -1;
      v.exp_busy  = (e != 0) ? 0 : ((v.exp_lat >= 0) ? v.exp_lat + 1 : -1);
      v.exp_hi500 = (v.div == 1) ? n5 : -1;
      do_vec($sformatf("rand%0d amt=%0d div=%0d", i, v.amt, v.div), v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
